// File: rtl/reg_bus_master.sv
// reg_bus_master: AXI4-Lite slave that issues single-cycle strobes on a 64-bit register bus
`timescale 1ns/1ps
module reg_bus_master #(
  parameter int RD_LATENCY = 6,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [63:0]       s_wdata,
  input  logic [7:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [63:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              o_reg_wen,
  output logic [15:0]       o_reg_waddr,
  output logic [63:0]       o_reg_wdata,
  output logic              o_reg_ren,
  output logic [15:0]       o_reg_raddr,
  input  logic [63:0]       i_reg_rdata,
  output logic              o_busy
);
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;
  state_t state;
  logic run, aw_full, w_full, last_rd, rd_ok;
  logic [ADDR_W-1:0] aw_addr;
  logic [63:0] w_data;
  logic [7:0] w_strb;
  logic [3:0] cnt;
  logic idle, wr_pend, wr_ok, ar_ok, rd_grant, wr_grant;
  assign idle = run && state == IDLE;
  assign wr_pend = aw_full && w_full;
  assign wr_ok = aw_addr[2:0] == 3'd0 && w_strb == 8'hFF;
  assign ar_ok = s_araddr[2:0] == 3'd0;
  assign rd_grant = idle && s_arvalid && !(wr_pend && last_rd);
  assign wr_grant = idle && wr_pend && !rd_grant;
  assign s_awready = idle && !aw_full;
  assign s_wready = idle && !w_full;
  assign s_arready = rd_grant;
  assign o_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      run <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      last_rd <= 1'b0;
      rd_ok <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      cnt <= '0;
      s_bresp <= '0;
      s_bvalid <= 1'b0;
      s_rdata <= '0;
      s_rresp <= '0;
      s_rvalid <= 1'b0;
      o_reg_wen <= 1'b0;
      o_reg_waddr <= '0;
      o_reg_wdata <= '0;
      o_reg_ren <= 1'b0;
      o_reg_raddr <= '0;
    end else begin
      run <= 1'b1;
      o_reg_wen <= 1'b0;
      o_reg_ren <= 1'b0;
      if (s_awvalid && s_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_full <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      case (state)
        IDLE:
          if (rd_grant) begin
            state <= RD_ISSUE;
            last_rd <= 1'b1;
            rd_ok <= ar_ok;
            o_reg_ren <= ar_ok;
            if (ar_ok) o_reg_raddr <= 16'(s_araddr);
          end else if (wr_grant) begin
            state <= WR_ISSUE;
            last_rd <= 1'b0;
            aw_full <= 1'b0;
            w_full <= 1'b0;
            o_reg_wen <= wr_ok;
            s_bresp <= wr_ok ? 2'b00 : 2'b10;
            if (wr_ok) begin
              o_reg_waddr <= 16'(aw_addr);
              o_reg_wdata <= w_data;
            end
          end
        WR_ISSUE: begin
          state <= WR_RESP;
          s_bvalid <= 1'b1;
        end
        WR_RESP:
          if (s_bready) begin
            state <= IDLE;
            s_bvalid <= 1'b0;
          end
        RD_ISSUE: begin
          state <= rd_ok ? RD_WAIT : RD_RESP;
          cnt <= 4'(RD_LATENCY - 1);
          s_rvalid <= !rd_ok;
          if (!rd_ok) begin
            s_rresp <= 2'b10;
            s_rdata <= '0;
          end
        end
        RD_WAIT:
          if (cnt == 4'd0) begin
            state <= RD_RESP;
            s_rvalid <= 1'b1;
            s_rdata <= i_reg_rdata;
            s_rresp <= 2'b00;
          end else cnt <= cnt - 4'd1;
        RD_RESP:
          if (s_rready) begin
            state <= IDLE;
            s_rvalid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: randomized AXI4-Lite traffic against a register-bus responder and reference model
`timescale 1ns/1ps
module tb_reg_bus_master;
  localparam int LAT = 6;
  logic clk = 1'b0, rst;
  logic [15:0] s_awaddr, s_araddr, o_reg_waddr, o_reg_raddr;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, o_reg_wen, o_reg_ren, o_busy;
  logic [63:0] s_wdata, s_rdata, o_reg_wdata, i_reg_rdata;
  logic [7:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  reg_bus_master #(.RD_LATENCY(LAT), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata),
    .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] init_val(input logic [15:0] a);
    return {16'hC0DE, a, ~a, 16'h5A5A};
  endfunction
  logic [63:0] regs [logic [15:0]];
  logic [63:0] model [logic [15:0]];
  function automatic logic [63:0] rd_word(input logic [15:0] a);
    return regs.exists(a) ? regs[a] : init_val(a);
  endfunction
  function automatic logic [63:0] exp_word(input logic [15:0] a);
    return model.exists(a) ? model[a] : init_val(a);
  endfunction
  // Register-block responder: data is valid on i_reg_rdata only LAT cycles after the read strobe
  int wen_cnt = 0, ren_cnt = 0, wen_cyc = 0, ren_cyc = 0, n_grants = 0, rd_age = -1;
  logic [15:0] wen_addr, rd_addr_q;
  logic [63:0] wen_data, ord = '0;
  always @(negedge clk) begin
    if (o_reg_wen) begin
      wen_cnt++;
      wen_cyc = cyc;
      wen_addr = o_reg_waddr;
      wen_data = o_reg_wdata;
      regs[o_reg_waddr] = o_reg_wdata;
      ord = {ord[62:0], 1'b0};
      n_grants++;
    end
    if (o_reg_ren) begin
      ren_cnt++;
      ren_cyc = cyc;
      rd_addr_q = o_reg_raddr;
      rd_age = 0;
      ord = {ord[62:0], 1'b1};
      n_grants++;
    end else if (rd_age >= 0 && rd_age <= LAT) rd_age++;
    i_reg_rdata = (rd_age == LAT) ? rd_word(rd_addr_q) : {$urandom, $urandom};
  end
  int aw_cyc, w_cyc, ar_cyc;
  task automatic send_aw(input logic [15:0] a);
    @(negedge clk);
    s_awaddr = a;
    s_awvalid = 1'b1;
    #1;
    for (int i = 0; i < 200 && !s_awready; i++) begin @(negedge clk); #1; end
    if (!s_awready) check("aw_handshake", s_awready, 1'b1);
    aw_cyc = cyc;
    @(posedge clk);
    #1 s_awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [63:0] d, input logic [7:0] st);
    @(negedge clk);
    s_wdata = d;
    s_wstrb = st;
    s_wvalid = 1'b1;
    #1;
    for (int i = 0; i < 200 && !s_wready; i++) begin @(negedge clk); #1; end
    if (!s_wready) check("w_handshake", s_wready, 1'b1);
    w_cyc = cyc;
    @(posedge clk);
    #1 s_wvalid = 1'b0;
  endtask
  task automatic send_ar(input logic [15:0] a);
    @(negedge clk);
    s_araddr = a;
    s_arvalid = 1'b1;
    #1;
    for (int i = 0; i < 200 && !s_arready; i++) begin @(negedge clk); #1; end
    if (!s_arready) check("ar_handshake", s_arready, 1'b1);
    ar_cyc = cyc;
    @(posedge clk);
    #1 s_arvalid = 1'b0;
  endtask
  task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] st, input int lead, input int bdly);
    bit ok;
    int w0, hs, n;
    ok = a[2:0] == 3'd0 && st == 8'hFF;
    w0 = wen_cnt;
    fork
      begin if (lead < 0) repeat (-lead) @(negedge clk); send_aw(a); end
      begin if (lead > 0) repeat (lead) @(negedge clk); send_w(d, st); end
    join
    if (ok) model[a] = d;
    hs = aw_cyc > w_cyc ? aw_cyc : w_cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_bvalid && n < 50);
    check("b_latency", 64'(cyc), 64'(hs + 3));
    check("wen_count", 64'(wen_cnt - w0), 64'(ok));
    if (ok) begin
      check("wen_latency", 64'(wen_cyc), 64'(hs + 2));
      check("waddr", wen_addr, a);
      check("wdata", wen_data, d);
    end
    repeat (bdly) @(negedge clk);
    check("bvalid_hold", s_bvalid, 1'b1);
    check("bresp", s_bresp, ok ? 2'b00 : 2'b10);
    s_bready = 1'b1;
    @(posedge clk);
    #1 s_bready = 1'b0;
  endtask
  task automatic do_read(input logic [15:0] a, input int rdly);
    bit ok;
    int r0, n;
    logic [63:0] exp;
    ok = a[2:0] == 3'd0;
    exp = ok ? exp_word(a) : 64'd0;
    r0 = ren_cnt;
    send_ar(a);
    n = 0;
    do begin @(negedge clk); n++; end while (!s_rvalid && n < 50);
    check("r_latency", 64'(cyc), 64'(ok ? ar_cyc + 2 + LAT : ar_cyc + 2));
    check("ren_count", 64'(ren_cnt - r0), 64'(ok));
    if (ok) check("ren_latency", 64'(ren_cyc), 64'(ar_cyc + 1));
    repeat (rdly) @(negedge clk);
    check("rvalid_hold", s_rvalid, 1'b1);
    check("rdata", s_rdata, exp);
    check("rresp", s_rresp, ok ? 2'b00 : 2'b10);
    s_rready = 1'b1;
    @(posedge clk);
    #1 s_rready = 1'b0;
  endtask
  initial begin
    logic [15:0] a;
    logic [7:0] st;
    logic [63:0] d;
    bit seen;
    int g0, n;
    rst = 1'b1;
    {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} = '0;
    s_awaddr = '0;
    s_araddr = '0;
    s_wdata = '0;
    s_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, o_reg_wen, o_reg_ren, o_busy}, 8'h00);
    check("reset_resp", {s_bresp, s_rresp}, 4'h0);
    check("reset_rdata", s_rdata, 64'd0);
    check("reset_wdata", o_reg_wdata, 64'd0);
    check("reset_addr", {o_reg_waddr, o_reg_raddr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    regs[16'h0038] = 64'h9000_0000_0000_0155;
    model[16'h0038] = 64'h9000_0000_0000_0155;
    do_write(16'h0020, 64'h0000_0000_8000_0000, 8'hFF, 0, 0);
    do_write(16'h0028, 64'h1122_3344_5566_7788, 8'hFF, -5, 1);
    do_read(16'h0038, 0);
    do_read(16'h0043, 1);
    do_write(16'h0030, 64'hDEAD_BEEF_0000_0001, 8'h0F, 0, 0);
    do_read(16'h0020, 2);
    do_read(16'h0030, 0);
    send_ar(16'h0038);
    repeat (3) @(negedge clk);
    check("busy_in_wait", o_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_ctl", {s_rvalid, s_bvalid, o_reg_ren, o_reg_wen, o_busy, s_arready, s_awready, s_wready}, 8'h00);
    check("abort_rdata", s_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); seen |= s_rvalid; end
    check("abort_no_rvalid", seen, 1'b0);
    do_read(16'h0038, 0);
    d = 64'h0BAD_F00D_1234_5678;
    fork send_aw(16'h0060); send_w(d, 8'hFF); join
    model[16'h0060] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_bvalid && n < 50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      {s_arvalid, s_awvalid, s_wvalid} = 3'b111;
      #1;
      check("bhold_block", {s_bvalid, s_arready, s_awready, s_wready}, 4'b1000);
    end
    @(negedge clk);
    {s_arvalid, s_awvalid, s_wvalid} = 3'b000;
    check("bhold_bresp", s_bresp, 2'b00);
    s_bready = 1'b1;
    @(posedge clk);
    #1 s_bready = 1'b0;
    do_read(16'h0060, 0);
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 15)) * 16'd8;
      if ($urandom_range(0, 3) == 0) a = a + 16'($urandom_range(1, 7));
      if ($urandom_range(0, 1) == 1) begin
        st = $urandom_range(0, 4) == 0 ? 8'($urandom) : 8'hFF;
        do_write(a, {$urandom, $urandom}, st, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      end else do_read(a, int'($urandom_range(0, 3)));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    g0 = n_grants;
    s_bready = 1'b1;
    s_rready = 1'b1;
    model[16'h0100] = 64'h0100_0100_0100_0100;
    model[16'h0108] = 64'h0108_0108_0108_0108;
    fork
      begin send_aw(16'h0100); send_aw(16'h0108); end
      begin send_w(64'h0100_0100_0100_0100, 8'hFF); send_w(64'h0108_0108_0108_0108, 8'hFF); end
      begin @(negedge clk); send_ar(16'h0040); send_ar(16'h0048); send_ar(16'h0050); end
    join
    n = 0;
    do begin @(negedge clk); n++; end while (o_busy && n < 100);
    s_bready = 1'b0;
    s_rready = 1'b0;
    check("arb_count", 64'(n_grants - g0), 64'd5);
    check("arb_order", ord[4:0], 5'b10101);
    do_read(16'h0100, 0);
    do_read(16'h0108, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
